pwm_timebase: RTL and testbench
===============================

PWM_TIMEBASE -- requirements
Module: pwm_timebase

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the width of the counter, period and compare values.
REQ-002 Parameter PSC_WIDTH, default 8, SHALL set the width of the prescaler.
REQ-003 Port CLK, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port RST_N, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-005 Port ENABLE, input, 1 bit, SHALL be the run request; high means count, low means idle.
REQ-006 Port ONE_SHOT, input, 1 bit, SHALL select a single period per ENABLE assertion when high.
REQ-007 Port WR_EN, input, 1 bit, SHALL be a one-cycle strobe that captures PSC_IN, PERIOD_IN, CCR_IN and CCR_ON_IN into the shadow registers.
REQ-008 Port PSC_IN, input, PSC_WIDTH bits, SHALL be the new prescaler value; the tick divides CLK by PSC+1.
REQ-009 Ports PERIOD_IN, CCR_IN and CCR_ON_IN, input, WIDTH bits each, SHALL be the new period and compare values.
REQ-010 Port CNT, output, WIDTH bits, SHALL be the timebase count fed to the comparator.
REQ-011 Ports PERIOD, CCR and CCR_ON, output, WIDTH bits each, SHALL be the active (applied) values fed to the comparator.
REQ-012 Port UPDATE_EVT, output, 1 bit, SHALL be a one-CLK pulse on each period wrap.
REQ-013 Port RUN, output, 1 bit, SHALL be high while the state machine is in RUN.

Function
REQ-014 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-015 The IDLE to RUN transition SHALL occur on the first cycle ENABLE is sampled high.
REQ-016 The RUN to IDLE transition SHALL occur when ENABLE is sampled low.
REQ-017 The RUN to DONE transition SHALL occur on a wrap while ONE_SHOT=1.
REQ-018 The DONE to IDLE transition SHALL occur when ENABLE is sampled low.
REQ-019 In IDLE and DONE, CNT and the prescaler count SHALL be held at 0 and UPDATE_EVT SHALL be 0.
REQ-020 In RUN, the prescaler SHALL count 0..PSC_active and assert an internal tick in the cycle where its count equals PSC_active, then return to 0.
REQ-021 On a tick with CNT < PERIOD, CNT SHALL increment by 1.
REQ-022 On a tick with CNT >= PERIOD, CNT SHALL wrap to 0 and UPDATE_EVT SHALL pulse for exactly 1 CLK.
REQ-023 If PERIOD=0, CNT SHALL remain 0 and UPDATE_EVT SHALL pulse on every tick.
REQ-024 If PSC_active=0, a tick SHALL occur every CLK.
REQ-025 A WR_EN pulse SHALL load the shadow registers and set a pending flag one cycle later.
REQ-026 On a wrap with pending=1, shadow SHALL be copied to active in the same edge as CNT returns to 0, and pending SHALL clear.
REQ-027 On a wrap with pending=0, the active values SHALL be unchanged.
REQ-028 If WR_EN and a wrap coincide, active SHALL take the old shadow, the new inputs SHALL go to shadow, and pending SHALL remain 1.
REQ-029 In IDLE with pending=1, shadow SHALL be copied to active on the next edge and pending SHALL clear, so a run starts with the latest values.
REQ-030 The active values SHALL never change mid-period in RUN; the comparator therefore sees glitch-free updates.
REQ-031 ENABLE dropping mid-period SHALL abort the period: CNT goes to 0 on the next edge, with no UPDATE_EVT.
REQ-032 All arithmetic SHALL be unsigned and comparisons WIDTH bits wide; CNT SHALL never exceed PERIOD when PERIOD is stable.
REQ-033 If an active PERIOD load makes CNT > PERIOD, CNT SHALL wrap on the next tick per REQ-022.

Reset
REQ-034 RST_N low SHALL force asynchronously: state IDLE; CNT, prescaler, shadow, active PERIOD/CCR/CCR_ON/PSC all 0; pending 0; UPDATE_EVT 0; RUN 0.
REQ-035 Reset deassertion SHALL be synchronous, and the block SHALL first act on the first CLK edge after RST_N rises.
REQ-036 Reset mid-run SHALL discard the pending shadow and SHALL produce no UPDATE_EVT.

Structure
REQ-037 A shared package pwm_pkg SHALL hold the default WIDTH and PSC_WIDTH constants and the state enum (IDLE, RUN, DONE).
REQ-038 The prescaler SHALL be one sub-module, pwm_prescaler, with inputs CLK, RST_N, clear, PSC and output tick.
REQ-039 Counter, shadow registers and state machine SHALL reside in pwm_timebase.

Verification
REQ-040 Wrap test: PSC=0, PERIOD=4, ENABLE=1 -> CNT 0,1,2,3,4,0,...; UPDATE_EVT high on each cycle CNT returns to 0.
REQ-041 Prescaler test: PSC=2, PERIOD=3 -> CNT advances every 3 CLK; one UPDATE_EVT per 12 CLK.
REQ-042 Shadow test: in RUN with PERIOD=9, write PERIOD_IN=5 at CNT=3 -> CNT reaches 9, wraps, PERIOD output changes to 5 at the wrap; next wrap after 5.
REQ-043 Coincident test: WR_EN on the wrap cycle with CCR_IN=7, old shadow CCR=2 -> CCR=2 after this wrap, CCR=7 after the following wrap.
REQ-044 One-shot test: ONE_SHOT=1, PERIOD=3 -> single count 0..3, one UPDATE_EVT, RUN=0, CNT held 0 until ENABLE is toggled low then high.
REQ-045 Abort/reset test: ENABLE low at CNT=5 -> CNT=0 next edge, no UPDATE_EVT; RST_N low mid-run -> all outputs 0 immediately, without waiting for CLK.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg
//   Shared constants and types for the PWM timebase slice.
//   - PWM_WIDTH_DEF     : default width of counter, period and compare values
//   - PWM_PSC_WIDTH_DEF : default width of the prescaler
//   - pwm_state_e       : timebase state machine encoding (IDLE, RUN, DONE)
package pwm_pkg;

  localparam int unsigned PWM_WIDTH_DEF     = 16;
  localparam int unsigned PWM_PSC_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pwm_state_e;

endpackage : pwm_pkg

// File: rtl/pwm_prescaler.sv
// pwm_prescaler
//   Clock divider for the PWM timebase. Counts 0..psc_i and raises tick_o
//   for one cycle when the count reaches psc_i, then restarts at 0. With
//   psc_i = 0 the tick is high every cycle.
// Ports
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   clear_i : hold the count at 0 and suppress the tick
//   psc_i   : division value (tick period = psc_i + 1 cycles)
//   tick_o  : one-cycle tick
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int unsigned PSC_WIDTH = PWM_PSC_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clear_i,
  input  logic [PSC_WIDTH-1:0] psc_i,
  output logic                 tick_o
);

  logic [PSC_WIDTH-1:0] cnt_q, cnt_d;

  // '>=' rather than '==' so a count left above a smaller psc_i can never
  // run the long way round through the full counter range.
  always_comb begin
    tick_o = 1'b0;
    cnt_d  = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q >= psc_i) begin
      tick_o = 1'b1;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : pwm_prescaler

// File: rtl/pwm_timebase.sv
// pwm_timebase
//   PWM timebase: prescaled up-counter with period wrap, shadowed
//   period/compare registers that only take effect at a wrap (or while
//   idle), and a one-shot mode.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | stopped, CNT = 0; pending shadow values are applied here
//   RUN   | prescaler and counter active; wraps pulse update_evt_o
//   DONE  | one-shot period finished; CNT held 0 until enable_i drops
//
// Ports
//   clk_i, rst_n_i           : clock and asynchronous active-low reset
//   enable_i                 : run request
//   one_shot_i               : stop after a single period per enable
//   wr_en_i                  : strobe capturing the *_in_i values into shadow
//   psc_in_i                 : new prescaler value (tick = clk / (psc + 1))
//   period_in_i, ccr_in_i,
//   ccr_on_in_i              : new period and compare values
//   cnt_o                    : timebase count
//   period_o, ccr_o, ccr_on_o: active values seen by the comparator
//   update_evt_o             : one-cycle pulse in the cycle CNT returns to 0
//   run_o                    : high while in RUN
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH     = PWM_WIDTH_DEF,
  parameter int unsigned PSC_WIDTH = PWM_PSC_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 enable_i,
  input  logic                 one_shot_i,
  input  logic                 wr_en_i,
  input  logic [PSC_WIDTH-1:0] psc_in_i,
  input  logic [WIDTH-1:0]     period_in_i,
  input  logic [WIDTH-1:0]     ccr_in_i,
  input  logic [WIDTH-1:0]     ccr_on_in_i,
  output logic [WIDTH-1:0]     cnt_o,
  output logic [WIDTH-1:0]     period_o,
  output logic [WIDTH-1:0]     ccr_o,
  output logic [WIDTH-1:0]     ccr_on_o,
  output logic                 update_evt_o,
  output logic                 run_o
);

  pwm_state_e state_q, state_d;

  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic                 update_evt_q, update_evt_d;
  logic                 pending_q, pending_d;

  logic [PSC_WIDTH-1:0] psc_q, psc_sh_q;
  logic [WIDTH-1:0]     period_q, period_sh_q;
  logic [WIDTH-1:0]     ccr_q, ccr_sh_q;
  logic [WIDTH-1:0]     ccr_on_q, ccr_on_sh_q;

  logic                 psc_clear;
  logic                 tick;
  logic                 wrap;
  logic                 apply;

  // Prescaler only runs in RUN with enable still high, so an abort also
  // restarts the prescale phase.
  assign psc_clear = (state_q != RUN) || !enable_i;

  pwm_prescaler #(
    .PSC_WIDTH (PSC_WIDTH)
  ) u_prescaler (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear_i (psc_clear),
    .psc_i   (psc_q),
    .tick_o  (tick)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    wrap    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_i) state_d = RUN;
      end
      RUN: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q;
          if (tick) begin
            // '>=' also catches CNT left above a newly applied shorter period.
            if (cnt_q >= period_q) begin
              wrap  = 1'b1;
              cnt_d = '0;
              if (one_shot_i) state_d = DONE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      DONE: begin
        if (!enable_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shadow values reach the comparator only at a period boundary or while
  // stopped, so the active set never changes mid-period.
  assign apply        = pending_q && (wrap || (state_q == IDLE));
  assign update_evt_d = wrap;

  // A write coinciding with an apply keeps pending set: the old shadow goes
  // active now and the new write waits for the next boundary.
  always_comb begin
    pending_d = pending_q;
    if (apply)   pending_d = 1'b0;
    if (wr_en_i) pending_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      update_evt_q <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      update_evt_q <= update_evt_d;
      pending_q    <= pending_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      psc_sh_q    <= '0;
      period_sh_q <= '0;
      ccr_sh_q    <= '0;
      ccr_on_sh_q <= '0;
    end else if (wr_en_i) begin
      psc_sh_q    <= psc_in_i;
      period_sh_q <= period_in_i;
      ccr_sh_q    <= ccr_in_i;
      ccr_on_sh_q <= ccr_on_in_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      psc_q    <= '0;
      period_q <= '0;
      ccr_q    <= '0;
      ccr_on_q <= '0;
    end else if (apply) begin
      psc_q    <= psc_sh_q;
      period_q <= period_sh_q;
      ccr_q    <= ccr_sh_q;
      ccr_on_q <= ccr_on_sh_q;
    end
  end

  assign cnt_o        = cnt_q;
  assign period_o     = period_q;
  assign ccr_o        = ccr_q;
  assign ccr_on_o     = ccr_on_q;
  assign update_evt_o = update_evt_q;
  assign run_o        = (state_q == RUN);

endmodule : pwm_timebase

// File: tb/tb_pwm_timebase.sv
// tb_pwm_timebase
//   Directed scenarios for pwm_timebase. Each scenario pushes the update
//   events it expects (gap in cycles, active period/ccr at the event) into a
//   queue; a negedge monitor pops and compares on every update_evt_o pulse.
//   The stimulus process checks count, run and reset values directly.
module tb_pwm_timebase;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        one_shot;
  logic        wr_en;
  logic [7:0]  psc_in;
  logic [15:0] period_in;
  logic [15:0] ccr_in;
  logic [15:0] ccr_on_in;
  logic [15:0] cnt;
  logic [15:0] period;
  logic [15:0] ccr;
  logic [15:0] ccr_on;
  logic        update_evt;
  logic        run;

  pwm_timebase dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .enable_i     (enable),
    .one_shot_i   (one_shot),
    .wr_en_i      (wr_en),
    .psc_in_i     (psc_in),
    .period_in_i  (period_in),
    .ccr_in_i     (ccr_in),
    .ccr_on_in_i  (ccr_on_in),
    .cnt_o        (cnt),
    .period_o     (period),
    .ccr_o        (ccr),
    .ccr_on_o     (ccr_on),
    .update_evt_o (update_evt),
    .run_o        (run)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          gap;
    logic [15:0] per;
    logic [15:0] ccr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   mark_cyc = 0;
  int   last_evt_cyc = 0;
  int   mon_base;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int gap, input logic [15:0] per, input logic [15:0] c);
    exp_t e;
    e.gap = gap;
    e.per = per;
    e.ccr = c;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] p, input logic [15:0] per,
                      input logic [15:0] c, input logic [15:0] c_on);
    psc_in    = p;
    period_in = per;
    ccr_in    = c;
    ccr_on_in = c_on;
    wr_en     = 1'b1;
    step();
    wr_en     = 1'b0;
    step();
  endtask

  // Monitor: every update pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (update_evt === 1'b1) begin
      mon_base = (last_evt_cyc > mark_cyc) ? last_evt_cyc : mark_cyc;
      chk("evt_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("evt_gap", cyc - mon_base, mon_e.gap);
        chk("evt_cnt", cnt, 0);
        chk("evt_period", period, mon_e.per);
        chk("evt_ccr", ccr, mon_e.ccr);
      end
      last_evt_cyc = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b1;
    enable    = 1'b0;
    one_shot  = 1'b0;
    wr_en     = 1'b0;
    psc_in    = '0;
    period_in = '0;
    ccr_in    = '0;
    ccr_on_in = '0;
    #1 rst_n  = 1'b0;
    #1;
    chk("rst_cnt", cnt, 0);
    chk("rst_period", period, 0);
    chk("rst_evt", update_evt, 0);
    chk("rst_run", run, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Wrap: PSC=0, PERIOD=4 -> 0,1,2,3,4,0,...
    load(8'd0, 16'd4, 16'd1, 16'd2);
    chk("load_period", period, 4);
    chk("load_ccr_on", ccr_on, 2);
    push(6, 16'd4, 16'd1);
    push(5, 16'd4, 16'd1);
    enable = 1'b1;
    mark_cyc = cyc;
    for (int k = 1; k <= 11; k++) begin
      step();
      chk("wrap_cnt", cnt, (k - 1) % 5);
      if (k == 1) chk("wrap_run", run, 1);
    end
    enable = 1'b0;
    step();
    chk("wrap_stop_run", run, 0);

    // Prescaler: PSC=2, PERIOD=3 -> CNT every 3 clk, event every 12 clk.
    load(8'd2, 16'd3, 16'd1, 16'd2);
    push(13, 16'd3, 16'd1);
    push(12, 16'd3, 16'd1);
    enable = 1'b1;
    mark_cyc = cyc;
    for (int k = 1; k <= 25; k++) begin
      step();
      chk("psc_cnt", cnt, ((k - 1) / 3) % 4);
    end
    enable = 1'b0;
    step();

    // Shadow: PERIOD=9, write PERIOD_IN=5 at CNT=3, applied at the wrap.
    load(8'd0, 16'd9, 16'd4, 16'd2);
    push(11, 16'd5, 16'd4);
    push(6, 16'd5, 16'd4);
    enable = 1'b1;
    mark_cyc = cyc;
    for (int k = 1; k <= 17; k++) begin
      step();
      chk("shadow_cnt", cnt, (k <= 10) ? (k - 1) : ((k - 11) % 6));
      if (k == 4) begin
        period_in = 16'd5;
        wr_en     = 1'b1;
      end
      if (k == 5) wr_en = 1'b0;
      if (k == 10) chk("shadow_hold_period", period, 9);
    end
    enable = 1'b0;
    step();

    // Coincident: shadow CCR=2 pending, WR_EN CCR_IN=7 in the wrap cycle.
    load(8'd0, 16'd3, 16'd0, 16'd2);
    push(5, 16'd3, 16'd2);
    push(4, 16'd3, 16'd7);
    push(4, 16'd3, 16'd7);
    enable = 1'b1;
    mark_cyc = cyc;
    for (int k = 1; k <= 13; k++) begin
      step();
      chk("coin_cnt", cnt, (k - 1) % 4);
      if (k == 2) begin
        ccr_in = 16'd2;
        wr_en  = 1'b1;
      end
      if (k == 3) wr_en = 1'b0;
      if (k == 4) begin
        chk("coin_ccr_old", ccr, 0);
        ccr_in = 16'd7;
        wr_en  = 1'b1;
      end
      if (k == 5) begin
        wr_en = 1'b0;
        chk("coin_ccr_first", ccr, 2);
      end
      if (k == 9) chk("coin_ccr_second", ccr, 7);
    end
    enable = 1'b0;
    step();

    // One-shot: PERIOD=3, single period then held until ENABLE toggles.
    load(8'd0, 16'd3, 16'd5, 16'd2);
    one_shot = 1'b1;
    push(5, 16'd3, 16'd5);
    push(5, 16'd3, 16'd5);
    enable = 1'b1;
    mark_cyc = cyc;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("os_cnt", cnt, (k <= 4) ? (k - 1) : 0);
      chk("os_run", run, (k <= 4) ? 1 : 0);
    end
    enable = 1'b0;
    step();
    step();
    enable = 1'b1;
    mark_cyc = cyc;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("os2_cnt", cnt, (k <= 4) ? (k - 1) : 0);
    end
    chk("os2_run", run, 0);
    enable   = 1'b0;
    one_shot = 1'b0;
    step();

    // Abort: ENABLE low at CNT=5 -> CNT=0 next edge, no event.
    load(8'd0, 16'd9, 16'd4, 16'd2);
    enable = 1'b1;
    mark_cyc = cyc;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("abort_cnt", cnt, k - 1);
    end
    enable = 1'b0;
    step();
    chk("abort_cnt0", cnt, 0);
    chk("abort_run", run, 0);
    step();

    // Reset mid-run with a pending write: asynchronous clear, pending lost.
    enable = 1'b1;
    mark_cyc = cyc;
    for (int k = 1; k <= 4; k++) step();
    period_in = 16'd7;
    wr_en     = 1'b1;
    step();
    wr_en = 1'b0;
    chk("pre_rst_cnt", cnt, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cnt", cnt, 0);
    chk("arst_period", period, 0);
    chk("arst_ccr", ccr, 0);
    chk("arst_ccr_on", ccr_on, 0);
    chk("arst_run", run, 0);
    chk("arst_evt", update_evt, 0);
    enable = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("rst_pending_discard", period, 0);

    // PERIOD=0 (active after reset): CNT stays 0, event on every tick.
    push(2, 16'd0, 16'd0);
    push(1, 16'd0, 16'd0);
    push(1, 16'd0, 16'd0);
    enable = 1'b1;
    mark_cyc = cyc;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("p0_cnt", cnt, 0);
    end
    enable = 1'b0;
    step();
    step();
    step();

    chk("evt_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pwm_timebase
